// File: rtl/fft32_sdiv_28s_14s_16_seq_if.sv
// Handshake/data bundle for the sequential signed divider.
// The master drives the request side (ce, start, operands); the slave
// (the divider) drives status and results.
interface fft32_sdiv_28s_14s_16_seq_if #(
  parameter int din0_WIDTH = 28,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 16
);
  logic                  ce;
  logic                  start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  busy;
  logic                  done;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH-1:0] rem;
  logic                  ovf;
  logic                  div0;

  modport master (
    output ce, start, din0, din1,
    input  busy, done, dout, rem, ovf, div0
  );

  modport slave (
    input  ce, start, din0, din1,
    output busy, done, dout, rem, ovf, div0
  );
endinterface

// File: rtl/fft32_sdiv_28s_14s_16_seq.sv
// Sequential signed divider: restoring shift/subtract on magnitudes, one
// quotient bit per enabled cycle, signs and special cases applied at the end.
// Results follow C semantics (truncate toward zero, remainder takes the
// dividend's sign).
// Optional feature macro: FFT32_SDIV_SAT_EN -- saturate an overflowing
// quotient and flag ovf; without it the quotient wraps and ovf stays 0.
module fft32_sdiv_28s_14s_16_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 28,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 16
) (
  input logic ap_clk,
  input logic ap_rst_n,
  fft32_sdiv_28s_14s_16_seq_if.slave bus
);

  localparam int QW = din0_WIDTH + 1;
  localparam int CW = $clog2(din0_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(din0_WIDTH - 1);
  localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  // Operand capture and iteration state
  logic [din0_WIDTH-1:0] dvnd;
  logic [din0_WIDTH-1:0] quo;
  logic [din1_WIDTH-1:0] dvsr;
  logic [din1_WIDTH-1:0] part;
  logic                  sign_n;
  logic                  sign_d;
  logic [CW-1:0]         cnt;

  // Registered results
  logic                  busy_r;
  logic                  done_r;
  logic [dout_WIDTH-1:0] dout_r;
  logic [din1_WIDTH-1:0] rem_r;
  logic                  ovf_r;
  logic                  div0_r;

  // Combinational helpers
  logic [din0_WIDTH-1:0] mag_n;
  logic [din1_WIDTH-1:0] mag_d;
  logic [din1_WIDTH:0]   trial;
  logic [din1_WIDTH:0]   diff;
  logic                  fits;
  logic [din1_WIDTH-1:0] part_next;
  logic                  neg_q;
  logic [QW-1:0]         q_mag;
  logic [QW-1:0]         q_signed;
  logic [dout_WIDTH-1:0] res_dout;
  logic [din1_WIDTH-1:0] res_rem;
  logic                  res_ovf;
  logic                  res_div0;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dout = dout_r;
  assign bus.rem  = rem_r;
  assign bus.ovf  = ovf_r;
  assign bus.div0 = div0_r;

  // Magnitudes of the incoming operands; the most negative value maps to
  // its exact unsigned magnitude, so no extra bit is needed.
  assign mag_n = bus.din0[din0_WIDTH-1] ? (-bus.din0) : bus.din0;
  assign mag_d = bus.din1[din1_WIDTH-1] ? (-bus.din1) : bus.din1;

  // One restoring step: bring down the next dividend bit and subtract the
  // divisor if the partial remainder is large enough.
  assign trial     = {part, quo[din0_WIDTH-1]};
  assign diff      = trial - {1'b0, dvsr};
  assign fits      = (trial >= {1'b0, dvsr});
  assign part_next = fits ? diff[din1_WIDTH-1:0] : trial[din1_WIDTH-1:0];

  // Signed quotient carries one extra bit so -min / -1 is still exact.
  assign neg_q    = sign_n ^ sign_d;
  assign q_mag    = {1'b0, quo};
  assign q_signed = neg_q ? (-q_mag) : q_mag;

`ifdef FFT32_SDIV_SAT_EN
  localparam logic signed [QW-1:0] QMAX = {{(QW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [QW-1:0] QMIN = {{(QW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};
  logic q_over;
  assign q_over = ($signed(q_signed) > QMAX) || ($signed(q_signed) < QMIN);
`endif

  // Final result selection: divide-by-zero, then overflow handling.
  always_comb begin
    res_dout = q_signed[dout_WIDTH-1:0];
    res_rem  = sign_n ? (-part) : part;
    res_ovf  = 1'b0;
    res_div0 = 1'b0;
    if (dvsr == '0) begin
      res_div0 = 1'b1;
      res_rem  = dvnd[din1_WIDTH-1:0];
      res_dout = dvnd[din0_WIDTH-1] ? DOUT_MIN : DOUT_MAX;
    end else begin
`ifdef FFT32_SDIV_SAT_EN
      if (q_over) begin
        res_dout = neg_q ? DOUT_MIN : DOUT_MAX;
        res_ovf  = 1'b1;
      end
`endif
    end
  end

  // State register, advancing only on enabled cycles.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      state <= IDLE;
    else if (bus.ce)
      state <= state_next;
  end

  // Next-state logic; start is only looked at in IDLE, so it is ignored
  // while a division is running.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == LAST_STEP) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers; everything holds when ce is low.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dvnd   <= '0;
      quo    <= '0;
      dvsr   <= '0;
      part   <= '0;
      sign_n <= 1'b0;
      sign_d <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dout_r <= '0;
      rem_r  <= '0;
      ovf_r  <= 1'b0;
      div0_r <= 1'b0;
    end else if (bus.ce) begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            dvnd   <= bus.din0;
            sign_n <= bus.din0[din0_WIDTH-1];
            sign_d <= bus.din1[din1_WIDTH-1];
            quo    <= mag_n;
            dvsr   <= mag_d;
            part   <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        CALC: begin
          part <= part_next;
          quo  <= {quo[din0_WIDTH-2:0], fits};
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          dout_r <= res_dout;
          rem_r  <= res_rem;
          ovf_r  <= res_ovf;
          div0_r <= res_div0;
        end
        DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
